gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Self-checking stimulus/response block for the basic-gate library. It drives the inputs of a single combinational gate under test, for example an inverter or NAND built from `Nand_G`. It then samples the gate's output and compares it against an expected truth table. It steps through every input vector in ascending order, counts mismatches and records the first failing vector. It sits in on-board self-test wrappers and in benches, one instance per gate under test.

## Interface
Parameters:
- `N_IN`, default 2: number of gate inputs; legal range 1..4.
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range ≥1.
- `TRUTH`, default 4'b0111 (NAND): expected output per vector; width 2^N_IN; bit i = expected output for input vector i.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a full exhaustive run; sampled only in IDLE or DONE.
- `dut_in`, out, N_IN: vector driven to the gate under test.
- `dut_out`, in, 1: gate-under-test output; treated as combinational and settled after `SETTLE` cycles.
- `busy`, out, 1: high from run acceptance until the final sample.
- `done`, out, 1: level; high after run completion until the next accepted start or reset.
- `pass`, out, 1: valid while `done`; 1 iff `err_count`==0.
- `err_count`, out, N_IN+1: number of mismatching vectors in the last run.
- `first_fail_vec`, out, N_IN: lowest-index mismatching vector; valid when `first_fail_valid`.
- `first_fail_valid`, out, 1: at least one mismatch recorded in the current/last run.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: when `start`=1, load vec=0, clear settle counter, `err_count` and `first_fail_valid`, then go to DRIVE.
- DRIVE: `dut_in`=vec. The counter increments each cycle. When counter==SETTLE-1, go to SAMPLE.
- SAMPLE (1 cycle): compare `dut_out` with TRUTH[vec].
  - On mismatch: `err_count`+=1. If `first_fail_valid`=0, latch `first_fail_vec`=vec and set `first_fail_valid`.
  - If vec==2^N_IN-1, go to DONE. Otherwise vec+=1, clear the counter and go to DRIVE.
- DONE: `done`=1 and `pass`=(err_count==0). `start`=1 restarts exactly as from IDLE, with `done` deasserting on the acceptance edge.
- `start` is ignored in DRIVE and SAMPLE.
- Arithmetic and width:
  - vec is an N_IN-bit counter and never wraps inside a run; the terminal compare precedes the increment.
  - `err_count` max is 2^N_IN, which fits in N_IN+1 bits; no saturation is needed.
- `dut_in` holds the last driven vector in DONE. It returns to 0 in IDLE and on reset.

## Timing
- Reset values: state=IDLE, `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_valid`=0.
- Reset has priority over everything. Reset mid-run aborts the run, and all outputs take their reset values on the reset edge; no partial results are retained.
- Start acceptance edge is E0:
  - `busy`=1 and `dut_in`=0 are visible after E0.
  - Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE, 1 in SAMPLE.
  - `dut_out` is sampled on the edge ending the SAMPLE cycle.
- Run length: `done`=1 and `busy`=0 after edge E0 + 2^N_IN·(SETTLE+1). Counters update on the same edge.
- `start` coincident with reset is lost.
- `start` held high continuously in DONE produces back-to-back runs, with `done` low for the full run duration.

## Structure
- Shared package `gate_ex_pkg`:
  - state enum;
  - truth-table constants: TT_NOT=2'b01, TT_NAND2=4'b0111, TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110, TT_XOR3=8'h96.
- One natural sub-module: `gate_ex_seq`, the vector/settle counter pair with `load`, `step`, `last_vec` and `settle_done` outputs. FSM, compare and result registers stay in the top.

## Test plan
- Inverter built from `Nand_G`, N_IN=1, TRUTH=TT_NOT, SETTLE=2, start pulse -> `done` 6 cycles after acceptance; `pass`=1, `err_count`=0, `first_fail_valid`=0.
- AND2 DUT checked against TT_NAND2, SETTLE=1 -> all 4 vectors mismatch; `err_count`=4, `first_fail_vec`=0, `pass`=0, `done` after 8 cycles.
- `dut_out` tied to 1, N_IN=2, TRUTH=TT_NAND2 -> `err_count`=1, `first_fail_vec`=3, `first_fail_valid`=1.
- XOR3 DUT, N_IN=3, TRUTH=TT_XOR3, SETTLE=1 -> `pass`=1 after 16 cycles; `dut_in` steps 0..7, each held 2 cycles.
- `start` pulsed during DRIVE of vec 1 -> ignored, timing unchanged. `start` held high in DONE -> rerun begins the next edge, `done` drops, and results clear.
- `rst` asserted for one cycle while vec=2 -> on the next cycle all outputs equal their reset values and the FSM is in IDLE. A following `start` runs cleanly from vec 0.

Source files
------------

// File: rtl/gate_ex_pkg.sv
// gate_ex_pkg: shared definitions for the gate exerciser.
//   gate_ex_state_e : sequencing FSM states (also exported on the debug port)
//   TT_*            : truth tables for common gates; bit i is the expected
//                     output when the gate inputs equal i.
package gate_ex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } gate_ex_state_e;

    localparam logic [1:0] TT_NOT   = 2'b01;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [7:0] TT_XOR3  = 8'h96;

endpackage

// File: rtl/gate_ex_seq.sv
// gate_ex_seq: input-vector counter plus settle counter.
//   clk, rst    : clock, synchronous active-high reset
//   load        : restart at vector 0 with the settle counter cleared
//   tick        : advance the settle counter by one
//   step        : move to the next vector and clear the settle counter
//   vec         : current input vector
//   last_vec    : vec is the all-ones (final) vector
//   settle_done : settle counter has reached SETTLE-1
// Priority is load > step > tick.
module gate_ex_seq #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            tick,
    input  logic            step,
    output logic [N_IN-1:0] vec,
    output logic            last_vec,
    output logic            settle_done
);

    // The counter only ranges 0..SETTLE-1, so clog2(SETTLE) bits suffice.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        vec_d = vec_q;
        cnt_d = cnt_q;
        if (load) begin
            vec_d = '0;
            cnt_d = '0;
        end else if (step) begin
            vec_d = vec_q + N_IN'(1);
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
            cnt_q <= '0;
        end else begin
            vec_q <= vec_d;
            cnt_q <= cnt_d;
        end
    end

    assign vec         = vec_q;
    assign last_vec    = (vec_q == VEC_LAST);
    assign settle_done = (cnt_q == CNT_LAST);

endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: exhaustively drives a combinational gate under test and
// checks its output against a truth table.
//   clk, rst         : clock, synchronous active-high reset
//   start            : run request, honoured only in IDLE or DONE
//   dut_in           : vector driven to the gate (0 in IDLE, last vector in DONE)
//   dut_out          : gate output, sampled at the end of each SAMPLE cycle
//   busy             : run in progress (DRIVE or SAMPLE)
//   done / pass      : run finished; pass when no vector mismatched
//   err_count        : mismatching vectors in the current/last run
//   first_fail_vec   : lowest mismatching vector, valid with first_fail_valid
//   state_dbg        : current FSM state
// Handshake: start is a request that is accepted on any rising edge where the
// FSM is in IDLE or DONE; done is a level that stays high until the next
// accepted start or reset, and results are stable while done is high.
module gate_exerciser
    import gate_ex_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter int                    SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]  TRUTH  = TT_NAND2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid,
    output logic [1:0]      state_dbg
);

    localparam int EW = N_IN + 1;

    gate_ex_state_e  state_q, state_d;
    logic [EW-1:0]   err_q, err_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            ffv_q, ffv_d;

    logic            seq_load, seq_tick, seq_step;
    logic [N_IN-1:0] vec;
    logic            last_vec, settle_done;
    logic            mismatch;

    gate_ex_seq #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .load        (seq_load),
        .tick        (seq_tick),
        .step        (seq_step),
        .vec         (vec),
        .last_vec    (last_vec),
        .settle_done (settle_done)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        ffvec_d  = ffvec_q;
        ffv_d    = ffv_q;
        seq_load = 1'b0;
        seq_tick = 1'b0;
        seq_step = 1'b0;
        mismatch = (dut_out != TRUTH[vec]);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    seq_load = 1'b1;
                    err_d    = '0;
                    ffvec_d  = '0;
                    ffv_d    = 1'b0;
                end
            end
            ST_DRIVE: begin
                // Holding the counter on the exit cycle keeps it within
                // 0..SETTLE-1 so it never needs an extra bit.
                if (settle_done) begin
                    state_d = ST_SAMPLE;
                end else begin
                    seq_tick = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + EW'(1);
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec;
                    end
                end
                // Terminal check before the increment: vec never wraps.
                if (last_vec) begin
                    state_d = ST_DONE;
                end else begin
                    seq_step = 1'b1;
                    state_d  = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= '0;
            ffvec_q <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ffvec_q <= ffvec_d;
            ffv_q   <= ffv_d;
        end
    end

    assign dut_in           = vec;
    assign busy             = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (err_q == '0);
    assign err_count        = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffv_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: four instances with different gates/parameters.
//   0: inverter from a NAND, N_IN=1, SETTLE=2, TT_NOT
//   1: AND2 checked against TT_NAND2, SETTLE=1
//   2: output tied high, TT_NAND2, SETTLE=2
//   3: XOR3, N_IN=3, SETTLE=1, TT_XOR3
module tb_gate_exerciser;
    import gate_ex_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    logic [3:0] start_v = '0;

    logic [0:0] in0;  logic out0, busy0, done0, pass0, ffv0; logic [1:0] err0; logic [0:0] ffvec0; logic [1:0] st0;
    logic [1:0] in1;  logic out1, busy1, done1, pass1, ffv1; logic [2:0] err1; logic [1:0] ffvec1; logic [1:0] st1;
    logic [1:0] in2;  logic out2, busy2, done2, pass2, ffv2; logic [2:0] err2; logic [1:0] ffvec2; logic [1:0] st2;
    logic [2:0] in3;  logic out3, busy3, done3, pass3, ffv3; logic [3:0] err3; logic [2:0] ffvec3; logic [1:0] st3;

    assign out0 = ~(in0[0] & in0[0]);  // inverter built from a NAND
    assign out1 = &in1;                // AND2
    assign out2 = 1'b1;                // stuck-high output
    assign out3 = ^in3;                // XOR3

    gate_exerciser #(.N_IN(1), .SETTLE(2), .TRUTH(TT_NOT)) u_not (
        .clk(clk), .rst(rst), .start(start_v[0]), .dut_in(in0), .dut_out(out0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffvec0), .first_fail_valid(ffv0), .state_dbg(st0));

    gate_exerciser #(.N_IN(2), .SETTLE(1), .TRUTH(TT_NAND2)) u_and (
        .clk(clk), .rst(rst), .start(start_v[1]), .dut_in(in1), .dut_out(out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffvec1), .first_fail_valid(ffv1), .state_dbg(st1));

    gate_exerciser #(.N_IN(2), .SETTLE(2), .TRUTH(TT_NAND2)) u_tie (
        .clk(clk), .rst(rst), .start(start_v[2]), .dut_in(in2), .dut_out(out2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffvec2), .first_fail_valid(ffv2), .state_dbg(st2));

    gate_exerciser #(.N_IN(3), .SETTLE(1), .TRUTH(TT_XOR3)) u_x3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .dut_in(in3), .dut_out(out3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail_vec(ffvec3), .first_fail_valid(ffv3), .state_dbg(st3));

    logic [3:0] done_v, pass_v, ffv_v;
    logic [4:0] err_v[4];
    logic [3:0] ffvec_v[4];
    assign done_v = {done3, done2, done1, done0};
    assign pass_v = {pass3, pass2, pass1, pass0};
    assign ffv_v  = {ffv3, ffv2, ffv1, ffv0};
    assign err_v[0] = {3'b0, err0};
    assign err_v[1] = {2'b0, err1};
    assign err_v[2] = {2'b0, err2};
    assign err_v[3] = {1'b0, err3};
    assign ffvec_v[0] = {3'b0, ffvec0};
    assign ffvec_v[1] = {2'b0, ffvec1};
    assign ffvec_v[2] = {2'b0, ffvec2};
    assign ffvec_v[3] = {1'b0, ffvec3};

    // ---------------- scoreboard ----------------
    // Word layout: {3'b0, id[1:0], pass, ffv, ffvec[3:0], err[4:0], done_cycle[15:0]}
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] pack_res(input logic [1:0] id, input logic p, input logic ffv,
                                             input logic [3:0] ffvec, input logic [4:0] err,
                                             input logic [15:0] dc);
        return {3'b0, id, p, ffv, ffvec, err, dc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: on each rising edge of done, pop the expected result and compare.
    logic [3:0] done_prev = '0;
    always @(negedge clk) begin : monitor
        logic [31:0] act_w;
        logic [31:0] exp_w;
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] && !done_prev[i]) begin
                act_w = pack_res(2'(i), pass_v[i], ffv_v[i], ffvec_v[i], err_v[i], cyc[15:0]);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done inst=%0d got=%08h", i, act_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (act_w !== exp_w) begin
                        errors++;
                        $display("FAIL result inst=%0d got=%08h want=%08h (id,pass,ffv,ffvec,err,cycle)",
                                 i, act_w, exp_w);
                    end
                end
            end
        end
        done_prev = done_v;
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic start_run(input int id, input int lat, input logic p, input logic ffv,
                             input logic [3:0] ffvec, input logic [4:0] err);
        start_v[id] = 1'b1;
        exp_q.push_back(pack_res(id[1:0], p, ffv, ffvec, err, 16'(cyc + 1 + lat)));
        @(negedge clk);
        start_v[id] = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got=%0d pending want=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_din",   32'(in2),    0);
        check("rst_busy",  32'(busy2),  0);
        check("rst_done",  32'(done2),  0);
        check("rst_pass",  32'(pass2),  0);
        check("rst_err",   32'(err2),   0);
        check("rst_ffv",   32'(ffv2),   0);
        check("rst_ffvec", 32'(ffvec2), 0);
        check("rst_state", 32'(st2),    32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Inverter: 2 vectors * 3 cycles
        start_run(0, 6, 1'b1, 1'b0, 4'd0, 5'd0);
        check("not_busy_e0", 32'(busy0), 1);
        check("not_din_e0",  32'(in0),   0);
        wait_drain("not");

        // AND2 against NAND2: every vector mismatches
        start_run(1, 8, 1'b0, 1'b1, 4'd0, 5'd4);
        wait_drain("and");

        // Tied high against NAND2, with an ignored start during vec 1 DRIVE
        start_run(2, 12, 1'b0, 1'b1, 4'd3, 5'd1);
        repeat (3) @(negedge clk);
        check("tie_vec1_drive", 32'(in2), 1);
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        check("tie_vec1_hold", 32'(in2), 1);
        check("tie_busy_mid",  32'(busy2), 1);
        wait_drain("tie");
        check("tie_done_level", 32'(done2), 1);
        check("tie_hold_din",   32'(in2),   3);

        // start held high in DONE: immediate rerun, done low throughout
        start_v[2] = 1'b1;
        exp_q.push_back(pack_res(2'd2, 1'b0, 1'b1, 4'd3, 5'd1, 16'(cyc + 1 + 12)));
        @(negedge clk);
        check("rerun_done_drop", 32'(done2), 0);
        check("rerun_err_clr",   32'(err2),  0);
        check("rerun_ffv_clr",   32'(ffv2),  0);
        check("rerun_din0",      32'(in2),   0);
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            check("rerun_done_low", 32'(done2), 0);
        end
        @(negedge clk);
        start_v[2] = 1'b0;
        wait_drain("rerun");

        // XOR3: dut_in walks 0..7, two cycles each
        start_run(3, 16, 1'b1, 1'b0, 4'd0, 5'd0);
        for (int k = 0; k < 16; k++) begin
            check("x3_din",  32'(in3),   32'(k / 2));
            check("x3_busy", 32'(busy3), 1);
            @(negedge clk);
        end
        check("x3_din_done",  32'(in3),   7);
        check("x3_busy_done", 32'(busy3), 0);
        wait_drain("x3");

        // Reset during vec 2 aborts the run; a start coincident with reset is lost
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        n = 0;
        while (in2 != 2'd2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_vec2", 32'(in2), 2);
        rst = 1'b1;
        start_v[2] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_v[2] = 1'b0;
        check("abort_state", 32'(st2),    32'(ST_IDLE));
        check("abort_din",   32'(in2),    0);
        check("abort_busy",  32'(busy2),  0);
        check("abort_done",  32'(done2),  0);
        check("abort_pass",  32'(pass2),  0);
        check("abort_err",   32'(err2),   0);
        check("abort_ffv",   32'(ffv2),   0);
        check("abort_ffvec", 32'(ffvec2), 0);
        check("abort_x3_done", 32'(done3), 0);
        @(negedge clk);
        check("abort_still_idle", 32'(st2), 32'(ST_IDLE));
        start_run(2, 12, 1'b0, 1'b1, 4'd3, 5'd1);
        check("post_rst_din0", 32'(in2), 0);
        wait_drain("post_rst");

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
